// File: rtl/mc_tx_pkg.sv
// Shared types and width helpers for the multi-channel transmitter.
// Optional macro TX_PARITY_EN adds a stored even-parity bit to each entry.
package mc_tx_pkg;

    localparam int TX_DATA_LEN = 8;
    localparam int TX_CHANNELS = 4;

    // Channel-id width; a single channel still carries a 1-bit id.
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int TX_CH_W = ch_w(TX_CHANNELS);

    typedef struct packed {
        logic [TX_CH_W-1:0]     chan;
        logic [TX_DATA_LEN-1:0] data;
`ifdef TX_PARITY_EN
        logic                   parity;
`endif
    } tx_entry_t;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with a registered head entry; pointers carry one extra
// wrap bit so full/empty come from the MSB compare.
module tx_fifo
    import mc_tx_pkg::*;
#(
    parameter type entry_t = tx_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk_syn,
    input  logic                       rst_target,
    input  logic                       push,
    input  entry_t                     din,
    input  logic                       pop,
    output entry_t                     dout,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    entry_t      head_q, head_d;
    logic        valid_q, valid_d;
    logic        push_ok, pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q + (AW+1)'(push_ok);
        rd_d    = rd_q + (AW+1)'(pop_ok);
        if (push_ok) mem_d[wr_q[AW-1:0]] = din;
        valid_d = (wr_d != rd_d);
        head_d  = '0;
        // When this push lands in the slot that becomes the head, bypass the array.
        if (valid_d) head_d = (push_ok && (wr_q == rd_d)) ? din : mem_q[rd_d[AW-1:0]];
    end

    always_ff @(posedge clk_syn or posedge rst_target) begin
        if (rst_target) begin
            wr_q    <= '0;
            rd_q    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            mem_q   <= mem_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = valid_q;
    assign level      = ($clog2(DEPTH+1))'(wr_q - rd_q);

endmodule

// File: rtl/mc_cdc_transmitter.sv
// Round-robin multi-channel transmitter on clk_syn feeding a tagged FIFO.
// Optional macro TX_PARITY_EN adds the out_parity port.
module mc_cdc_transmitter
    import mc_tx_pkg::*;
#(
    parameter int DATA_LEN = TX_DATA_LEN,
    parameter int CHANNELS = TX_CHANNELS,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_syn,
    input  logic                         rst_target,
    input  logic [CHANNELS*DATA_LEN-1:0] in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [DATA_LEN-1:0]          out_data,
    output logic [ch_w(CHANNELS)-1:0]    out_chan,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
`ifdef TX_PARITY_EN
    output logic                         out_parity,
`endif
    output logic                         overflow
);

    localparam int CH_W = ch_w(CHANNELS);
    localparam int CW   = $clog2(DEPTH+1);

    typedef struct packed {
        logic [CH_W-1:0]     chan;
        logic [DATA_LEN-1:0] data;
`ifdef TX_PARITY_EN
        logic                parity;
`endif
    } entry_t;

    logic [CH_W-1:0] rr_q, rr_d, gidx;
    logic [CW-1:0]   blk_cnt_q, blk_cnt_d;
    logic            overflow_q, overflow_d;
    logic            found, space, pop, full, empty, blocked;
    int              c;
    entry_t          din, head;

    assign pop   = out_valid & out_ready;
    assign space = ~full | pop;

    // Rotating priority search starting at rr_q; reset also withholds grants.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        c     = 0;
        if (space && !rst_target) begin
            for (int k = 0; k < CHANNELS; k++) begin
                c = int'(rr_q) + k;
                if (c >= CHANNELS) c = c - CHANNELS;
                if (!found && in_valid[c]) begin
                    found = 1'b1;
                    gidx  = CH_W'(c);
                end
            end
        end
        in_ready = found ? (CHANNELS'(1) << gidx) : '0;
        rr_d     = rr_q;
        if (found) rr_d = (int'(gidx) == CHANNELS-1) ? '0 : gidx + CH_W'(1);
    end

    always_comb begin
        din      = '0;
        din.chan = gidx;
        din.data = in_data[int'(gidx)*DATA_LEN +: DATA_LEN];
`ifdef TX_PARITY_EN
        din.parity = ^din.data;
`endif
    end

    // Overflow watches for a source stalled by a full FIFO for DEPTH cycles.
    always_comb begin
        blocked    = (|in_valid) & ~space;
        blk_cnt_d  = '0;
        if (blocked) blk_cnt_d = (int'(blk_cnt_q) >= DEPTH) ? blk_cnt_q : blk_cnt_q + CW'(1);
        overflow_d = overflow_q | (blocked && (int'(blk_cnt_q) >= DEPTH-1));
    end

    always_ff @(posedge clk_syn or posedge rst_target) begin
        if (rst_target) begin
            rr_q       <= '0;
            blk_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            blk_cnt_q  <= blk_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    tx_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_syn    (clk_syn),
        .rst_target (rst_target),
        .push       (found),
        .din        (din),
        .pop        (pop),
        .dout       (head),
        .dout_valid (out_valid),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    assign out_data = head.data;
    assign out_chan = head.chan;
    assign overflow = overflow_q;
`ifdef TX_PARITY_EN
    assign out_parity = head.parity;
`endif

endmodule

// File: tb/tb_mc_cdc_transmitter.sv
// Directed bench for mc_cdc_transmitter (DATA_LEN=8, CHANNELS=4, DEPTH=4).
// Parity scenario is compiled in when TX_PARITY_EN is defined.
module tb_mc_cdc_transmitter;

    logic        clk_syn = 1'b0;
    logic        rst_target;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
`ifdef TX_PARITY_EN
    logic        out_parity;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_syn = ~clk_syn;

    mc_cdc_transmitter #(.DATA_LEN(8), .CHANNELS(4), .DEPTH(4)) dut (
        .clk_syn    (clk_syn),
        .rst_target (rst_target),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
`ifdef TX_PARITY_EN
        .out_parity (out_parity),
`endif
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk_syn);
        #1;
    endtask

    task automatic do_reset();
        rst_target = 1'b1;
        in_valid   = '0;
        out_ready  = 1'b0;
        tick();
        rst_target = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_target = 1'b1;
        in_valid   = 4'b0100;
        in_data    = 32'hFFFF_FFFF;
        out_ready  = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
        n_cmp++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_chan got %0d want 0", out_chan); end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        in_data   = 32'h00A5_0000;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #2;
        n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", in_ready); end
        tick();
        in_valid = '0;
        #2;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", out_data); end
        n_cmp++; if (out_chan !== 2'd2) begin n_fail++; $display("FAIL single_chan got %0d want 2", out_chan); end
        n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL single_pop valid=%b level=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [1:0] exp_ch;
        do_reset();
        in_data   = 32'h1312_1110;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 4'hF;
            #2;
            exp_gnt = 4'b0001 << (i % 4);
            n_cmp++; if (in_ready !== exp_gnt) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, in_ready, exp_gnt); end
            if (i > 0) begin
                exp_ch = 2'((i - 1) % 4);
                n_cmp++; if (out_chan !== exp_ch || out_data !== {6'h04, exp_ch}) begin
                    n_fail++; $display("FAIL rr_head[%0d] got ch%0d/%h want ch%0d/%h", i, out_chan, out_data, exp_ch, {6'h04, exp_ch});
                end
                n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL rr_level[%0d] got %0d want 1", i, level); end
            end
            tick();
        end
        in_valid = '0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL rr_drain valid=%b level=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        in_data   = '0;
        for (int k = 0; k < 4; k++) begin
            in_valid      = 4'b0010;
            in_data[15:8] = 8'h30 + 8'(k);
            #2;
            n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL full_push[%0d] got %b want 0010", k, in_ready); end
            tick();
        end
        in_data[15:8] = 8'h34;
        #2;
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level got %0d want 4", level); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL full_blocked got %b want 0000", in_ready); end
        for (int b = 0; b < 4; b++) begin
            tick();
            n_cmp++; if (overflow !== (b == 3)) begin n_fail++; $display("FAIL full_overflow[%0d] got %b want %b", b, overflow, (b == 3)); end
            n_cmp++; if (out_data !== 8'h30) begin n_fail++; $display("FAIL full_hold[%0d] got %h want 30", b, out_data); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL full_pushpop_grant got %b want 0010", in_ready); end
        tick();
        in_valid = '0;
        #1;
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_level got %0d want 4", level); end
        n_cmp++; if (out_data !== 8'h31) begin n_fail++; $display("FAIL full_pushpop_head got %h want 31", out_data); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_sticky got %b want 1", overflow); end
    endtask

    task automatic test_drain();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h31 + 8'(k) || out_chan !== 2'd1) begin
                n_fail++; $display("FAIL drain[%0d] got v%b ch%0d %h want v1 ch1 %h", k, out_valid, out_chan, out_data, 8'h31 + 8'(k));
            end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL drain_empty valid=%b level=%0d want 0/0", out_valid, level); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL drain_underflow valid=%b level=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_data   = 32'h5A00_0000;
        in_valid  = 4'b1000;
        tick();
        in_data[31:24] = 8'h5B;
        tick();
        n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL mid_level_before got %0d want 2", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_overflow_before got %b want 1", overflow); end
        #2;
        rst_target = 1'b1;
        #1;
        n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset level=%0d valid=%b ovf=%b want 0/0/0", level, out_valid, overflow);
        end
        n_cmp++; if (out_data !== 8'h00 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset_out data=%h ch=%0d rdy=%b want 00/0/0000", out_data, out_chan, in_ready);
        end
        in_valid   = '0;
        #1;
        rst_target = 1'b0;
        tick();
        n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after level=%0d valid=%b want 0/0", level, out_valid); end
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        do_reset();
        out_ready = 1'b0;
        in_data   = 32'h0000_0007;
        in_valid  = 4'b0001;
        tick();
        #1;
        n_cmp++; if (out_data !== 8'h07 || out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_07 got %h/%b want 07/1", out_data, out_parity); end
        out_ready = 1'b1;
        in_data   = 32'h0000_0003;
        tick();
        in_valid = '0;
        #1;
        n_cmp++; if (out_data !== 8'h03 || out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_03 got %h/%b want 03/0", out_data, out_parity); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_drain();
        test_reset_mid();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
